generation_scheduler: RTL and testbench

- Sequences each Game of Life generation: starts life_logic, paces generations by frame count, and issues a single-cycle double_buffer swap only at a VGA frame boundary.
- Replaces the ad-hoc swap logic in top_level.
- Sits between life_logic (start/done), renderer (vsync) and double_buffer (swap).
- Supports free-run at a switch-selected speed, pause, and single-step.

---
 rtl/generation_scheduler.sv | 109 ++++++++++
 tb/tb_generation_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/generation_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : generation_scheduler
// Purpose  : Sequences one Game of Life generation at a time: starts
//            life_logic, paces generations by VGA frame count, and issues a
//            single-cycle double_buffer swap only on a frame boundary.
//            Supports free-run at a selectable speed, pause and single-step.
// Revision : 1.0  initial release
// ============================================================================
module generation_scheduler #(
  parameter int LOG_MAX_SPEED   = 3,
  parameter int GEN_COUNT_WIDTH = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       run_in,
  input  logic                       step_in,
  input  logic [LOG_MAX_SPEED-1:0]   speed_in,
  input  logic                       vsync_in,
  input  logic                       logic_done_in,
  output logic                       logic_start_out,
  output logic                       swap_out,
  output logic                       busy_out,
  output logic [GEN_COUNT_WIDTH-1:0] gen_count_out
);

  // One extra bit so the slowest setting (2**LOG_MAX_SPEED frames) fits.
  localparam int CNT_W = LOG_MAX_SPEED + 1;
  localparam logic [CNT_W-1:0] MAX_FRAMES = CNT_W'(2 ** LOG_MAX_SPEED);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    COMPUTE    = 3'd2,
    WAIT_FRAME = 3'd3,
    SWAP       = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           frame_cnt_q, frame_cnt_d;
  logic [GEN_COUNT_WIDTH-1:0] gen_count_q, gen_count_d;
  logic                       vsync_q;

  logic                       tick;
  logic                       last_frame;
  logic [CNT_W-1:0]           frame_cnt_dec;
  logic [CNT_W-1:0]           frames_per_gen;

  // Falling edge of the active-low vsync marks the start of a new frame.
  assign tick           = vsync_q & ~vsync_in;
  assign last_frame     = (frame_cnt_q <= CNT_W'(1));
  assign frame_cnt_dec  = (frame_cnt_q == '0) ? '0 : frame_cnt_q - CNT_W'(1);
  assign frames_per_gen = MAX_FRAMES - {1'b0, speed_in};

  // State, frame counter, generation counter and vsync history registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      gen_count_q <= '0;
      vsync_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      gen_count_q <= gen_count_d;
      vsync_q     <= vsync_in;
    end
  end

  // Next-state logic; swaps are only ever launched from a frame tick.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    gen_count_d = gen_count_q;
    case (state_q)
      IDLE: begin
        // step_in seen in any other state is simply dropped.
        if (run_in | step_in) state_d = START;
      end
      START: begin
        // speed_in is sampled only here; a tick in this cycle is ignored.
        frame_cnt_d = frames_per_gen;
        state_d     = COMPUTE;
      end
      COMPUTE: begin
        if (tick) frame_cnt_d = frame_cnt_dec;
        if (logic_done_in & tick & last_frame) state_d = SWAP;
        else if (logic_done_in)                state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        // With the count already at zero the swap waits for the next tick.
        if (tick) frame_cnt_d = frame_cnt_dec;
        if (tick & last_frame) state_d = SWAP;
      end
      SWAP: begin
        gen_count_d = gen_count_q + GEN_COUNT_WIDTH'(1);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign logic_start_out = (state_q == START);
  assign swap_out        = (state_q == SWAP);
  assign busy_out        = (state_q != IDLE);
  assign gen_count_out   = gen_count_q;

endmodule
`default_nettype wire

// File: tb/tb_generation_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_generation_scheduler
// Purpose  : Directed self-checking bench for generation_scheduler.
// Revision : 1.0  initial release
// ============================================================================
module tb_generation_scheduler;

  localparam int LMS = 3;
  localparam int GW  = 4;

  logic          clk = 1'b0;
  logic          rst_in, run_in, step_in, vsync_in, logic_done_in;
  logic [LMS-1:0] speed_in;
  logic          logic_start_out, swap_out, busy_out;
  logic [GW-1:0] gen_count_out;

  int checks    = 0;
  int failures  = 0;
  int start_cnt = 0;
  int swap_cnt  = 0;
  logic prev_start = 1'b0;
  logic prev_swap  = 1'b0;

  generation_scheduler #(
    .LOG_MAX_SPEED  (LMS),
    .GEN_COUNT_WIDTH(GW)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .run_in         (run_in),
    .step_in        (step_in),
    .speed_in       (speed_in),
    .vsync_in       (vsync_in),
    .logic_done_in  (logic_done_in),
    .logic_start_out(logic_start_out),
    .swap_out       (swap_out),
    .busy_out       (busy_out),
    .gen_count_out  (gen_count_out)
  );

  always #5 clk = ~clk;

  // Pulse counters and one-hot/one-cycle invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (logic_start_out === 1'b1) start_cnt++;
    if (swap_out === 1'b1) swap_cnt++;
    if (rst_in === 1'b0) begin
      checks++;
      assert (!((logic_start_out === 1'b1 && swap_out === 1'b1) ||
                (logic_start_out === 1'b1 && prev_start === 1'b1) ||
                (swap_out === 1'b1 && prev_swap === 1'b1)))
      else begin
        failures++;
        $error("FAIL invariant observed start=%b swap=%b prev_start=%b prev_swap=%b expected no overlap",
               logic_start_out, swap_out, prev_start, prev_swap);
      end
    end
    prev_start = logic_start_out;
    prev_swap  = swap_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks and land 1 time unit after the last rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle low vsync pulse; returns in the cycle after the tick edge.
  task automatic fall();
    vsync_in = 1'b0;
    cyc(1);
    vsync_in = 1'b1;
  endtask

  initial begin
    rst_in = 1'b1; run_in = 1'b1; step_in = 1'b0; vsync_in = 1'b1;
    logic_done_in = 1'b0; speed_in = 3'd7;

    // 1. reset held 3 cycles with run_in=1, then first start
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("rst_start", 32'(logic_start_out), 32'd0);
      chk("rst_swap",  32'(swap_out),        32'd0);
      chk("rst_busy",  32'(busy_out),        32'd0);
      chk("rst_gen",   32'(gen_count_out),   32'd0);
    end
    rst_in = 1'b0;
    cyc(1);
    chk("first_start", 32'(logic_start_out), 32'd1);
    chk("first_busy",  32'(busy_out),        32'd1);
    cyc(1);
    chk("start_one_cycle", 32'(logic_start_out), 32'd0);
    chk("compute_busy",    32'(busy_out),        32'd1);

    // 2. fast pacing N=1: done at +20, vsync fall at +100
    cyc(18);
    logic_done_in = 1'b1;
    cyc(80);
    chk("fast_no_early_swap", 32'(swap_cnt), 32'd0);
    fall();
    chk("fast_swap", 32'(swap_out), 32'd1);
    logic_done_in = 1'b0;
    speed_in = 3'd0;
    cyc(1);
    chk("fast_gen",       32'(gen_count_out),   32'd1);
    chk("fast_idle_gap",  32'(logic_start_out), 32'd0);
    cyc(1);
    chk("fast_restart",   32'(logic_start_out), 32'd1);

    // 3. slow pacing N=8: done at +50, ticks every 1000 cycles
    cyc(49);
    logic_done_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc(999);
      if (i == 8) begin
        chk("slow_no_early_swap", 32'(swap_cnt), 32'd1);
        run_in = 1'b0;
      end
      fall();
      chk("slow_swap_tick", 32'(swap_out), (i == 8) ? 32'd1 : 32'd0);
    end
    logic_done_in = 1'b0;
    cyc(1);
    chk("slow_gen",  32'(gen_count_out), 32'd2);
    chk("slow_idle", 32'(busy_out),      32'd0);
    cyc(2);
    chk("paused_no_start", 32'(start_cnt), 32'd2);

    // 4. slow logic via step, N=1: done after 3rd tick -> swap on 4th
    speed_in = 3'd7;
    step_in = 1'b1;
    cyc(1);
    step_in = 1'b0;
    chk("step_start", 32'(logic_start_out), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(5);
      fall();
      chk("slowlogic_no_swap", 32'(swap_out), 32'd0);
    end
    logic_done_in = 1'b1;
    cyc(3);
    chk("wait_no_midframe_swap", 32'(swap_out), 32'd0);
    chk("wait_busy",             32'(busy_out), 32'd1);
    fall();
    chk("slowlogic_swap", 32'(swap_out), 32'd1);
    logic_done_in = 1'b0;
    cyc(1);
    chk("slowlogic_gen", 32'(gen_count_out), 32'd3);

    // 5. step while busy is dropped
    step_in = 1'b1;
    cyc(1);
    step_in = 1'b0;
    cyc(1);
    step_in = 1'b1;
    cyc(1);
    step_in = 1'b0;
    logic_done_in = 1'b1;
    cyc(2);
    fall();
    chk("step_swap", 32'(swap_out), 32'd1);
    logic_done_in = 1'b0;
    cyc(4);
    chk("step_dropped", 32'(start_cnt),     32'd4);
    chk("step_idle",    32'(busy_out),      32'd0);
    chk("step_gen",     32'(gen_count_out), 32'd4);

    // 6. reset mid-COMPUTE aborts with no swap
    step_in = 1'b1;
    cyc(1);
    step_in = 1'b0;
    cyc(3);
    rst_in = 1'b1;
    cyc(1);
    rst_in = 1'b0;
    chk("abort_idle", 32'(busy_out),      32'd0);
    chk("abort_gen",  32'(gen_count_out), 32'd0);
    logic_done_in = 1'b1;
    fall();
    cyc(3);
    chk("abort_no_swap", 32'(swap_cnt), 32'd4);

    // gen_count wrap: 2**GW fast generations bring the count back to 0
    for (int k = 1; k <= 16; k++) begin
      step_in = 1'b1;
      cyc(1);
      step_in = 1'b0;
      cyc(1);
      fall();
      cyc(1);
      if (k == 15) chk("gen_max",  32'(gen_count_out), 32'd15);
      if (k == 16) chk("gen_wrap", 32'(gen_count_out), 32'd0);
    end
    chk("total_swaps",  32'(swap_cnt),  32'd20);
    chk("total_starts", 32'(start_cnt), 32'd21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
